// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and load/store.
// Data has fixed priority; a starvation counter forces fetch through.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [15:0]       o_if_rdata,
  input  logic [1:0]        i_d_action,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_stall,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_IF   = 2'd1,
    RET_D    = 2'd2
  } ret_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  ret_e              ret_q, ret_d;
  logic              hsel_q, hsel_d;
  logic [15:0]       if_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  logic d_rd, d_wr, d_pend, if_win, d_win;
  logic [15:0] if_half;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[0], i_d_addr[1:0]};

  assign d_rd   = (i_d_action == 2'b01);
  assign d_wr   = (i_d_action == 2'b10);
  assign d_pend = d_rd | d_wr;
  assign if_win = i_if_req & (~d_pend | (starve_q == SMAX));
  assign d_win  = d_pend & ~if_win;

  assign o_if_gnt    = if_win;
  assign o_d_gnt     = d_win;
  assign o_stall     = i_if_req & ~if_win;
  assign o_mem_en    = if_win | d_win;
  assign o_mem_we    = d_win & d_wr;
  assign o_mem_addr  = d_win ? i_d_addr[ADDR_W-1:2]
                             : i_if_addr[ADDR_W-1:2];
  assign o_mem_wdata = i_d_wdata;

  // Next-state: starvation count, return owner, halfword select.
  always_comb begin
    starve_d = starve_q;
    ret_d    = RET_NONE;
    hsel_d   = hsel_q;
    if (!i_if_req || if_win) begin
      starve_d = 4'd0;
    end else if (d_win && starve_q < SMAX) begin
      starve_d = starve_q + 4'd1;
    end
    if (if_win) begin
      ret_d  = RET_IF;
      hsel_d = i_if_addr[1];
    end else if (d_win && d_rd) begin
      ret_d = RET_D;
    end
  end

  // Route RAM read data to whichever requester owns the return.
  assign if_half     = hsel_q ? i_mem_rdata[31:16]
                              : i_mem_rdata[15:0];
  assign o_if_rvalid = (ret_q == RET_IF);
  assign o_d_rvalid  = (ret_q == RET_D);
  assign o_if_rdata  = o_if_rvalid ? if_half : if_hold_q;
  assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : d_hold_q;

  // Arbiter state plus held copies of the last returned data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_q  <= 4'd0;
      ret_q     <= RET_NONE;
      hsel_q    <= 1'b0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      starve_q <= starve_d;
      ret_q    <= ret_d;
      hsel_q   <= hsel_d;
      if (o_if_rvalid) if_hold_q <= if_half;
      if (o_d_rvalid)  d_hold_q  <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [15:0] o_if_rdata;
  logic [1:0]  i_d_action;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_stall;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:255];

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr[7:0]] <= o_mem_wdata;
      else          i_mem_rdata <= ram[o_mem_addr[7:0]];
    end
  end

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid),
    .o_if_rdata(o_if_rdata),
    .i_d_action(i_d_action), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
    .o_d_rdata(o_d_rdata), .o_stall(o_stall),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h0;
    i_d_action = 2'b00; i_d_addr = 32'h0; i_d_wdata = 32'h0;
    #1;
    checks++;
    if (o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rvalid: got %b/%b expected 0/0",
               o_if_rvalid, o_d_rvalid);
    end
    checks++;
    if (o_if_rdata !== 16'h0 || o_d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h/%h expected 0/0",
               o_if_rdata, o_d_rdata);
    end
    step(); step();
    checks++;
    if (o_if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_rvalid: got %b expected 0", o_if_rvalid);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_if_gnt !== 1'b1 || o_mem_addr !== 30'h0) begin
      errors++;
      $display("FAIL rst_rel_gnt: got gnt=%b addr=%h expected 1/0",
               o_if_gnt, o_mem_addr);
    end
    step();
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 16'hABCD) begin
      errors++;
      $display("FAIL fetch_lo: got v=%b d=%h expected 1/abcd",
               o_if_rvalid, o_if_rdata);
    end
    i_if_addr = 32'h2;
    step();
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL fetch_hi: got v=%b d=%h expected 1/1234",
               o_if_rvalid, o_if_rdata);
    end
    i_if_req = 1'b0;
    step();
    checks++;
    if (o_if_rvalid !== 1'b0 || o_if_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL fetch_hold: got v=%b d=%h expected 0/1234",
               o_if_rvalid, o_if_rdata);
    end
  endtask

  task automatic test_contend();
    i_if_req = 1'b1; i_if_addr = 32'h4;
    i_d_action = 2'b01; i_d_addr = 32'h8;
    #1;
    checks++;
    if (o_d_gnt !== 1'b1 || o_if_gnt !== 1'b0 || o_stall !== 1'b1
        || o_mem_addr !== 30'h2) begin
      errors++;
      $display("FAIL contend_d: got d=%b if=%b st=%b a=%h expected 1/0/1/2",
               o_d_gnt, o_if_gnt, o_stall, o_mem_addr);
    end
    step();
    i_d_action = 2'b00;
    #1;
    checks++;
    if (o_if_gnt !== 1'b1 || o_stall !== 1'b0 || o_mem_addr !== 30'h1) begin
      errors++;
      $display("FAIL contend_if: got if=%b st=%b a=%h expected 1/0/1",
               o_if_gnt, o_stall, o_mem_addr);
    end
    checks++;
    if (o_d_rvalid !== 1'b1 || o_d_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL contend_drd: got v=%b d=%h expected 1/cafef00d",
               o_d_rvalid, o_d_rdata);
    end
    step();
    i_if_req = 1'b0;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 16'h2222
        || o_d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL contend_ifrd: got v=%b d=%h dv=%b expected 1/2222/0",
               o_if_rvalid, o_if_rdata, o_d_rvalid);
    end
    step();
  endtask

  task automatic test_write_read();
    i_d_action = 2'b10; i_d_addr = 32'h40; i_d_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (o_d_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_en !== 1'b1
        || o_mem_addr !== 30'h10) begin
      errors++;
      $display("FAIL wr_gnt: got g=%b we=%b en=%b a=%h expected 1/1/1/10",
               o_d_gnt, o_mem_we, o_mem_en, o_mem_addr);
    end
    step();
    i_d_action = 2'b01;
    #1;
    checks++;
    if (o_d_rvalid !== 1'b0 || o_if_rvalid !== 1'b0 || o_mem_we !== 1'b0
        || o_d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wr_norv: got dv=%b iv=%b we=%b g=%b expected 0/0/0/1",
               o_d_rvalid, o_if_rvalid, o_mem_we, o_d_gnt);
    end
    step();
    i_d_action = 2'b00;
    checks++;
    if (o_d_rvalid !== 1'b1 || o_d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_back: got v=%b d=%h expected 1/deadbeef",
               o_d_rvalid, o_d_rdata);
    end
    step();
    checks++;
    if (o_d_rvalid !== 1'b0 || o_d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_hold: got v=%b d=%h expected 0/deadbeef",
               o_d_rvalid, o_d_rdata);
    end
  endtask

  task automatic test_starve();
    logic exp_if;
    i_if_req = 1'b1; i_if_addr = 32'h0;
    i_d_action = 2'b01; i_d_addr = 32'h8;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_if = (c % 5 == 4);
      checks++;
      if (o_if_gnt !== exp_if || o_d_gnt !== ~exp_if
          || o_stall !== ~exp_if) begin
        errors++;
        $display("FAIL starve_c%0d: got if=%b d=%b st=%b expected %b/%b/%b",
                 c, o_if_gnt, o_d_gnt, o_stall, exp_if, ~exp_if, ~exp_if);
      end
      step();
    end
    i_if_req = 1'b0; i_d_action = 2'b00;
    step();
  endtask

  task automatic test_reset_inflight();
    i_d_action = 2'b01; i_d_addr = 32'h8;
    step();
    i_d_action = 2'b00;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_d_rvalid !== 1'b0 || o_if_rvalid !== 1'b0
        || o_d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_flight: got dv=%b iv=%b d=%h expected 0/0/0",
               o_d_rvalid, o_if_rvalid, o_d_rdata);
    end
    step();
    i_rst = 1'b0;
    step();
    checks++;
    if (o_d_rvalid !== 1'b0 || o_if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got dv=%b iv=%b expected 0/0",
               o_d_rvalid, o_if_rvalid);
    end
  endtask

  task automatic test_action11();
    i_if_req = 1'b0; i_d_action = 2'b11; i_d_addr = 32'h40;
    #1;
    checks++;
    if (o_mem_en !== 1'b0 || o_d_gnt !== 1'b0 || o_if_gnt !== 1'b0
        || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL act11: got en=%b d=%b if=%b st=%b expected 0/0/0/0",
               o_mem_en, o_d_gnt, o_if_gnt, o_stall);
    end
    step();
    checks++;
    if (o_d_rvalid !== 1'b0 || ram[8'h10] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL act11_nowr: got dv=%b m=%h expected 0/deadbeef",
               o_d_rvalid, ram[8'h10]);
    end
    i_d_action = 2'b00;
  endtask

  initial begin
    ram[0] = 32'h1234ABCD;
    ram[1] = 32'h11112222;
    ram[2] = 32'hCAFEF00D;
    test_reset();
    test_contend();
    test_write_read();
    test_starve();
    test_reset_inflight();
    test_action11();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that lets instruction fetch and load/store share one RAM in place of the separate instruction ROM and data RAM. It sits between the PC/fetch stage, the control block's RAM action outputs and one word-wide synchronous RAM. Each cycle it grants at most one access. Data has fixed priority, backed by a starvation counter that forces a fetch grant. It drives the stall that holds the PC while a fetch is waiting.

## Interface
- ADDR_W, 32, byte address width of both requesters
- DATA_W, 32, RAM word width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; range 1..15
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_if_req  in  1  fetch request
- i_if_addr  in  ADDR_W  fetch byte address; bit 1 selects the halfword, bit 0 ignored
- o_if_gnt  out  1  fetch granted this cycle (combinational)
- o_if_rvalid  out  1  o_if_rdata valid (registered)
- o_if_rdata  out  16  instruction halfword
- i_d_action  in  2  00 none, 01 read, 10 write, 11 treated as none
- i_d_addr  in  ADDR_W  data byte address; bits [1:0] ignored
- i_d_wdata  in  DATA_W  store data
- o_d_gnt  out  1  data access granted this cycle (combinational); for a write, this is completion
- o_d_rvalid  out  1  o_d_rdata valid (registered)
- o_d_rdata  out  DATA_W  load data
- o_stall  out  1  i_if_req & ~o_if_gnt; PC must hold
- o_mem_en  out  1  RAM access this cycle
- o_mem_we  out  1  RAM write
- o_mem_addr  out  ADDR_W-2  word address, taken as granted addr[ADDR_W-1:2]
- o_mem_wdata  out  DATA_W  equals i_d_wdata
- i_mem_rdata  in  DATA_W  RAM read data, valid one cycle after o_mem_en & ~o_mem_we

## Operation
- Decision is combinational from the current requests and registered state:
  - data pending = i_d_action is 01 or 10;
  - fetch wins if data is not pending, or if starve_cnt == STARVE_MAX;
  - otherwise data wins.
- Exactly one of o_if_gnt or o_d_gnt is asserted when any request is pending. Neither is asserted when no request is pending.
- o_mem_en = o_if_gnt | o_d_gnt.
- o_mem_we = o_d_gnt & (i_d_action == 10).
- o_mem_addr is muxed from the winner's address.
- starve_cnt, 4 bits, updates on each clock edge:
  - cleared when fetch is granted or i_if_req is low;
  - incremented when i_if_req is high and data is granted;
  - saturates at STARVE_MAX.
- Return tracking register ret_sel encodes NONE, IF or D:
  - loaded each cycle with the owner of a granted read;
  - loaded NONE for a write or no grant.
- Each cycle, ret_sel routes i_mem_rdata:
  - IF: o_if_rvalid=1, and o_if_rdata = i_mem_rdata[31:16] if the latched addr bit 1 is 1, else [15:0];
  - D: o_d_rvalid=1, o_d_rdata = i_mem_rdata;
  - NONE: both rvalid low.
- The latched fetch addr bit 1 is captured at grant.
- rdata outputs hold their last value when rvalid is low.
- Requesters hold request, address and data stable until granted. The arbiter keeps no request queue.

## Timing
- Grant latency: 0 cycles in the same cycle as the request when uncontended. A fetch contending with data waits at most STARVE_MAX cycles.
- Read latency: data appears with rvalid exactly 1 cycle after grant.
- Write completes at the grant edge.
- Throughput: one access per cycle. Back-to-back reads are allowed, because a new grant in cycle N+1 overlaps the return of the cycle-N read.
- Reset (async, immediate): ret_sel=NONE, starve_cnt=0, o_if_rvalid=0, o_d_rvalid=0, o_if_rdata=0, o_d_rdata=0, latched halfword select=0.
- Combinational outputs follow their inputs during reset. The RAM is not reset.
- Reset asserted with a read in flight: the return is dropped and no rvalid is produced after reset releases.
- Simultaneous requests with starve_cnt < STARVE_MAX: data wins and o_stall=1.
- Simultaneous requests with starve_cnt == STARVE_MAX: fetch wins, o_d_gnt=0, and the counter clears.
- i_d_action=11: treated as idle, never granted, never written.

## Test plan
- Reset with i_if_req=1 held, then release: after release o_if_gnt=1 and o_mem_addr = i_if_addr>>2. The next cycle o_if_rvalid=1. With RAM word 0x1234ABCD at word 0: addr 0x0 returns 0xABCD, addr 0x2 returns 0x1234.
- Fetch and data read contend for one cycle: o_d_gnt=1, o_stall=1; the next cycle o_if_gnt=1 and o_d_rvalid=1 with the loaded word, and the cycle after that o_if_rvalid=1.
- Data write 0xDEADBEEF to 0x40, then data read of 0x40: the write sets o_mem_we=1 with no rvalid, and the read returns 0xDEADBEEF one cycle after its grant.
- Starvation, STARVE_MAX=4, both requests held continuously: grant pattern D,D,D,D,IF and repeat. o_stall is low only in the IF cycles.
- Reset asserted in the cycle after a read grant: both rvalids are 0 immediately and stay 0 after release until a new grant.
- i_d_action=11 with no fetch: o_mem_en=0 and no grant.
